mbr_unit: RTL

- Memory Buffer Register stage, directly upstream of the buffer register.
- Holds the 16-bit datum exchanged with main memory and drives it onto the MBR-to-BR path that feeds the ALU.
- Runs a req/ack handshake with memory for reads and writes, has a timeout watchdog, and reports busy to the control unit for stalling.

---
 rtl/cpu_ctrl_pkg.sv | 19 +
 rtl/mbr_watchdog.sv | 32 +++
 rtl/mbr_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: control-word bit positions,
// MBR state encoding and default datapath widths.
package cpu_ctrl_pkg;

    localparam int CS_MBR_RD     = 8;
    localparam int CS_MBR_WR     = 9;
    localparam int CS_MBR_LD_ACC = 10;

    localparam int MBR_ADDR_W  = 8;
    localparam int MBR_DATA_W  = 16;
    localparam int MBR_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mbr_state_t;

endpackage

// File: rtl/mbr_watchdog.sv
// Cycle counter that flags a memory transaction stuck without ack.
// TIMEOUT of zero disables expiry entirely.
module mbr_watchdog
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = MBR_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CW-1:0] cnt;

    assign expire = (TIMEOUT != 0) && enable && (cnt == CW'(LIM));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mbr_unit.sv
// Memory buffer register: holds the memory datum, runs the req/ack
// handshake with main memory and feeds the buffer register path.
module mbr_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int ADDR_W  = MBR_ADDR_W,
    parameter int DATA_W  = MBR_DATA_W,
    parameter int TIMEOUT = MBR_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       control_signal,
    input  logic [ADDR_W-1:0] MARtoMBR,
    input  logic [DATA_W-1:0] ACCtoMBR,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] MBRtoBR,
    output logic              mbr_busy,
    output logic              mbr_err
);

    mbr_state_t        state, state_nx;
    logic [DATA_W-1:0] mbr, mbr_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              req_nx, we_nx, err_nx;
    logic              expire;
    logic              cmd_rd, cmd_wr, cmd_ld;
    logic              unused_ctrl;

    assign cmd_rd = control_signal[CS_MBR_RD];
    assign cmd_wr = control_signal[CS_MBR_WR];
    assign cmd_ld = control_signal[CS_MBR_LD_ACC];

    assign unused_ctrl = ^control_signal;

    assign mbr_busy = (state != IDLE);
    assign MBRtoBR  = mbr;

    mbr_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .enable(mbr_busy && !mem_ack),
        .expire(expire)
    );

    always_comb begin
        state_nx = state;
        mbr_nx   = mbr;
        wdata_nx = mem_wdata;
        addr_nx  = mem_addr;
        req_nx   = mem_req;
        we_nx    = mem_we;
        err_nx   = mbr_err;
        unique case (state)
            IDLE: begin
                if (cmd_ld) begin
                    mbr_nx = ACCtoMBR;
                end
                if (cmd_rd && cmd_wr) begin
                    err_nx = 1'b1;
                end else if (cmd_wr) begin
                    addr_nx  = MARtoMBR;
                    we_nx    = 1'b1;
                    req_nx   = 1'b1;
                    err_nx   = 1'b0;
                    wdata_nx = cmd_ld ? ACCtoMBR : mbr;
                    state_nx = WRITE;
                end else if (cmd_rd) begin
                    addr_nx  = MARtoMBR;
                    we_nx    = 1'b0;
                    req_nx   = 1'b1;
                    err_nx   = 1'b0;
                    state_nx = READ;
                end
            end
            READ, WRITE: begin
                // Ack beats a simultaneous watchdog expiry.
                if (mem_ack) begin
                    if (state == READ) begin
                        mbr_nx = mem_rdata;
                    end
                    req_nx   = 1'b0;
                    state_nx = IDLE;
                end else if (expire) begin
                    req_nx   = 1'b0;
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                req_nx   = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mbr       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mbr_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            mbr       <= mbr_nx;
            mem_req   <= req_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            mbr_err   <= err_nx;
        end
    end

endmodule
